// File: rtl/row_window_gen_if.sv
// Stream bundle for the row window generator: raster beats in,
// column-aligned row triplets plus framing flags out.
interface row_window_gen_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic                  s_tuser;
    logic                  s_tlast;
    logic [DATA_WIDTH-1:0] m_top;
    logic [DATA_WIDTH-1:0] m_mid;
    logic [DATA_WIDTH-1:0] m_bot;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tuser;
    logic                  m_tlast;
    logic                  m_first_row;
    logic                  m_last_row;
    logic                  err_line_len;

    modport slave (
        input  s_tdata, s_tvalid, s_tuser, s_tlast, m_tready,
        output s_tready, m_top, m_mid, m_bot, m_tvalid,
        output m_tuser, m_tlast, m_first_row, m_last_row,
        output err_line_len
    );

    modport master (
        output s_tdata, s_tvalid, s_tuser, s_tlast, m_tready,
        input  s_tready, m_top, m_mid, m_bot, m_tvalid,
        input  m_tuser, m_tlast, m_first_row, m_last_row,
        input  err_line_len
    );
endinterface

// File: rtl/row_window_gen.sv
// Vertical 3-row window generator: two line stores hold the previous
// rows, top and bottom image rows are replicated at the borders.
module row_window_gen #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int PIXEL_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT
) (
    input  logic            clk,
    input  logic            aresetn,
    row_window_gen_if.slave bus
);
    localparam int BPR = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CW  = $clog2(BPR);
    localparam int RW  = $clog2(IMAGE_DIM);
    localparam logic [CW-1:0] COL_LAST = CW'(BPR - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_DIM - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  err;

    logic                  p0_wr, p0_out, p0_flush;
    logic                  p0_tuser, p0_tlast, p0_first, p0_last;
    logic [CW-1:0]         p0_col;
    logic [DATA_WIDTH-1:0] p0_data;

    logic                  p1_out, p1_flush;
    logic                  p1_tuser, p1_tlast, p1_first, p1_last;
    logic [DATA_WIDTH-1:0] p1_data, rd0, rd1;

    logic                  m_valid, m_user, m_last, m_first_row, m_last_row;
    logic [DATA_WIDTH-1:0] top, mid, bot;

    logic [DATA_WIDTH-1:0] l0 [BPR];
    logic [DATA_WIDTH-1:0] l1 [BPR];

    logic stall, ready, acc, start, abort, col_end, len_bad;

    assign stall   = m_valid & ~bus.m_tready;
    assign ready   = ~stall & (state != FLUSH);
    assign acc     = bus.s_tvalid & ready;
    assign start   = acc & bus.s_tuser & (state == IDLE);
    assign abort   = acc & bus.s_tuser & ((state == PRIME) | (state == RUN));
    assign col_end = (col == COL_LAST);
    assign len_bad = bus.s_tlast != col_end;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state <= IDLE;
            col <= '0;
            row <= '0;
            err <= 1'b0;
            p0_wr <= 1'b0;
            p0_out <= 1'b0;
            p0_flush <= 1'b0;
            p0_tuser <= 1'b0;
            p0_tlast <= 1'b0;
            p0_first <= 1'b0;
            p0_last <= 1'b0;
            p0_col <= '0;
            p0_data <= '0;
            p1_out <= 1'b0;
            p1_flush <= 1'b0;
            p1_tuser <= 1'b0;
            p1_tlast <= 1'b0;
            p1_first <= 1'b0;
            p1_last <= 1'b0;
            p1_data <= '0;
            m_valid <= 1'b0;
            m_user <= 1'b0;
            m_last <= 1'b0;
            m_first_row <= 1'b0;
            m_last_row <= 1'b0;
            top <= '0;
            mid <= '0;
            bot <= '0;
        end else if (!stall) begin
            p0_wr <= 1'b0;
            p0_out <= 1'b0;
            p0_flush <= 1'b0;
            p0_tuser <= 1'b0;
            p0_tlast <= col_end;
            p0_first <= 1'b0;
            p0_last <= 1'b0;
            p0_col <= col;
            p0_data <= bus.s_tdata;
            // A mid-frame SOF restarts the frame with this beat as row 0 col 0
            if (start | abort) begin
                p0_wr <= 1'b1;
                p0_col <= '0;
                col <= CW'(1);
                row <= '0;
                err <= abort;
                state <= PRIME;
            end else begin
                unique case (state)
                    PRIME: if (acc) begin
                        p0_wr <= 1'b1;
                        err <= err | len_bad;
                        if (col_end) begin
                            col <= '0;
                            row <= RW'(1);
                            state <= RUN;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    RUN: if (acc) begin
                        p0_wr <= 1'b1;
                        p0_out <= 1'b1;
                        p0_first <= (row == RW'(1));
                        p0_tuser <= (row == RW'(1)) & (col == '0);
                        err <= err | len_bad;
                        if (col_end) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row <= '0;
                                state <= FLUSH;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    FLUSH: begin
                        p0_out <= 1'b1;
                        p0_flush <= 1'b1;
                        p0_last <= 1'b1;
                        if (col_end) begin
                            col <= '0;
                            state <= IDLE;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            p1_out <= p0_out & ~abort;
            p1_flush <= p0_flush;
            p1_tuser <= p0_tuser;
            p1_tlast <= p0_tlast;
            p1_first <= p0_first;
            p1_last <= p0_last;
            p1_data <= p0_data;
            m_valid <= p1_out & ~abort;
            m_user <= p1_tuser;
            m_last <= p1_tlast;
            m_first_row <= p1_first;
            m_last_row <= p1_last;
            top <= p1_first ? rd0 : rd1;
            mid <= rd0;
            bot <= p1_flush ? rd0 : p1_data;
        end
    end

    // Read-before-write: rd0/l1 see the previous row while l0 takes the new beat
    always_ff @(posedge clk) begin
        if (!stall) begin
            rd0 <= l0[p0_col];
            rd1 <= l1[p0_col];
            if (p0_wr) begin
                l0[p0_col] <= p0_data;
                if (p0_out)
                    l1[p0_col] <= l0[p0_col];
            end
        end
    end

    assign bus.s_tready     = ready;
    assign bus.m_top        = top;
    assign bus.m_mid        = mid;
    assign bus.m_bot        = bot;
    assign bus.m_tvalid     = m_valid;
    assign bus.m_tuser      = m_user;
    assign bus.m_tlast      = m_last;
    assign bus.m_first_row  = m_first_row;
    assign bus.m_last_row   = m_last_row;
    assign bus.err_line_len = err;
endmodule

// File: tb/tb_row_window_gen.sv
// Bench for row_window_gen: frame-level reference model, spot-check table,
// latency, backpressure, framing error, SOF abort and mid-frame reset.
module tb_row_window_gen;
    localparam int PPB = 16;
    localparam int PW  = 8;
    localparam int DIM = 64;
    localparam int DW  = PPB * PW;
    localparam int BPR = DIM / PPB;
    localparam int NB  = DIM * BPR;

    typedef logic [DW-1:0] beat_t;
    typedef struct packed {
        beat_t top;
        beat_t mid;
        beat_t bot;
        logic  tuser;
        logic  tlast;
        logic  first;
        logic  last;
    } out_t;
    typedef struct {
        int         idx;
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
        logic       tuser;
        logic       tlast;
        logic       first;
        logic       last;
    } vec_t;

    logic  clk = 1'b0;
    logic  aresetn = 1'b0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    rnd_ready = 1'b0;
    bit    was_stall = 1'b0;
    out_t  held;
    beat_t img [DIM][BPR];
    out_t  got[$];
    out_t  exp_q[$];
    out_t  exp_old[$];
    vec_t  tbl [7];

    always #5 clk = ~clk;

    row_window_gen_if #(.DATA_WIDTH(DW)) bus ();

    row_window_gen #(
        .PIXELS_PER_BEAT(PPB),
        .PIXEL_WIDTH(PW),
        .IMAGE_DIM(DIM),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .bus(bus)
    );

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic out_t cur_out();
        return {bus.m_top, bus.m_mid, bus.m_bot, bus.m_tuser,
                bus.m_tlast, bus.m_first_row, bus.m_last_row};
    endfunction

    always @(negedge clk) begin
        if (was_stall && aresetn)
            check("stall_hold", {bus.m_tvalid, cur_out()}, {1'b1, held});
        was_stall = aresetn && bus.m_tvalid && !bus.m_tready;
        held = cur_out();
        if (aresetn && mon_en && bus.m_tvalid && bus.m_tready)
            got.push_back(cur_out());
    end

    always @(posedge clk) begin
        #1;
        bus.m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(beat_t d, bit u, bit l);
        bit ok;
        ok = 1'b0;
        bus.s_tdata = d;
        bus.s_tuser = u;
        bus.s_tlast = l;
        bus.s_tvalid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.s_tready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            tick();
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_tready low for 2000 cycles");
        end
    endtask

    task automatic send_range(int from, int to, bit gaps, bit err3);
        for (int k = from; k < to; k++) begin
            int r;
            int c;
            r = k / BPR;
            c = k % BPR;
            send(img[r][c], k == 0, (c == BPR-1) || (err3 && r == 3 && c == 2));
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.s_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        bus.s_tvalid = 1'b0;
    endtask

    task automatic fill_img(bit rowidx);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < BPR; c++)
                if (rowidx)
                    img[r][c] = {PPB{8'(r)}};
                else
                    img[r][c] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Window of each centre row, clamped at the image borders
    task automatic build_exp();
        out_t e;
        exp_q.delete();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < BPR; c++) begin
                e.top = img[(r > 0) ? r-1 : 0][c];
                e.mid = img[r][c];
                e.bot = img[(r < DIM-1) ? r+1 : DIM-1][c];
                e.tuser = (r == 0) && (c == 0);
                e.tlast = (c == BPR-1);
                e.first = (r == 0);
                e.last = (r == DIM-1);
                exp_q.push_back(e);
            end
    endtask

    task automatic wait_outputs(string name, int n);
        for (int i = 0; i < 4000 && got.size() < n; i++)
            tick();
        repeat (12) tick();
        check(name, got.size(), n);
    endtask

    task automatic compare_frame(string name, int off);
        for (int i = 0; i < NB; i++)
            if (off + i < got.size())
                check($sformatf("%s_beat%0d", name, i), got[off+i], exp_q[i]);
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_tvalid"}, bus.m_tvalid, 0);
        check({tag, "_tuser"}, bus.m_tuser, 0);
        check({tag, "_tlast"}, bus.m_tlast, 0);
        check({tag, "_first"}, bus.m_first_row, 0);
        check({tag, "_last"}, bus.m_last_row, 0);
        check({tag, "_err"}, bus.err_line_len, 0);
        check({tag, "_top"}, bus.m_top, 0);
        check({tag, "_mid"}, bus.m_mid, 0);
        check({tag, "_bot"}, bus.m_bot, 0);
        check({tag, "_sready"}, bus.s_tready, 1);
    endtask

    initial begin
        int n;
        tbl[0] = '{0,   8'd0,  8'd0,  8'd1,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{3,   8'd0,  8'd0,  8'd1,  1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{4,   8'd0,  8'd1,  8'd2,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{22,  8'd4,  8'd5,  8'd6,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{23,  8'd4,  8'd5,  8'd6,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{252, 8'd62, 8'd63, 8'd63, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{255, 8'd62, 8'd63, 8'd63, 1'b0, 1'b1, 1'b0, 1'b1};

        bus.s_tvalid = 1'b0;
        bus.s_tdata = '0;
        bus.s_tuser = 1'b0;
        bus.s_tlast = 1'b0;
        aresetn = 1'b0;
        repeat (3) tick();
        reset_checks("rst");
        aresetn = 1'b1;
        tick();
        mon_en = 1'b1;

        // Row-index frame with first-output latency probe
        fill_img(1'b1);
        build_exp();
        got.delete();
        send_range(0, BPR + 1, 1'b0, 1'b0);
        check("lat_e0", bus.m_tvalid, 0);
        tick();
        check("lat_e1", bus.m_tvalid, 0);
        tick();
        check("lat_valid", bus.m_tvalid, 1);
        check("lat_tuser", bus.m_tuser, 1);
        check("lat_first", bus.m_first_row, 1);
        send_range(BPR + 1, NB, 1'b0, 1'b0);
        wait_outputs("f1_count", NB);
        compare_frame("f1", 0);
        for (int i = 0; i < 7; i++)
            if (tbl[i].idx < got.size()) begin
                out_t g;
                g = got[tbl[i].idx];
                check($sformatf("tbl%0d_top", i), g.top, {PPB{tbl[i].top}});
                check($sformatf("tbl%0d_mid", i), g.mid, {PPB{tbl[i].mid}});
                check($sformatf("tbl%0d_bot", i), g.bot, {PPB{tbl[i].bot}});
                check($sformatf("tbl%0d_flags", i),
                      {g.tuser, g.tlast, g.first, g.last},
                      {tbl[i].tuser, tbl[i].tlast, tbl[i].first, tbl[i].last});
            end
        n = 0;
        foreach (got[i]) n += int'(got[i].tuser);
        check("f1_tuser_count", n, 1);
        n = 0;
        foreach (got[i]) n += int'(got[i].tlast);
        check("f1_tlast_count", n, DIM);

        // Random data, random gaps and random backpressure
        fill_img(1'b0);
        build_exp();
        got.delete();
        rnd_ready = 1'b1;
        send_range(0, NB, 1'b1, 1'b0);
        wait_outputs("f2_count", NB);
        compare_frame("f2", 0);
        rnd_ready = 1'b0;

        // Early s_tlast on row 3 col 2
        fill_img(1'b1);
        build_exp();
        got.delete();
        send_range(0, 15, 1'b0, 1'b1);
        check("err_set", bus.err_line_len, 1);
        send_range(15, NB, 1'b0, 1'b1);
        wait_outputs("f3_count", NB);
        compare_frame("f3", 0);
        check("err_sticky", bus.err_line_len, 1);
        got.delete();
        send_range(0, 1, 1'b0, 1'b0);
        check("err_clear", bus.err_line_len, 0);
        send_range(1, NB, 1'b0, 1'b0);
        wait_outputs("f4_count", NB);
        compare_frame("f4", 0);

        // SOF injected at row 10 col 1: old beats 4..38 escape
        fill_img(1'b0);
        build_exp();
        exp_old = exp_q;
        got.delete();
        send_range(0, 10*BPR + 1, 1'b0, 1'b0);
        fill_img(1'b0);
        build_exp();
        send_range(0, 1, 1'b0, 1'b0);
        check("abort_err", bus.err_line_len, 1);
        send_range(1, NB, 1'b0, 1'b0);
        wait_outputs("abort_count", NB + 35);
        for (int i = 0; i < 35; i++)
            if (i < got.size())
                check($sformatf("abort_old%0d", i), got[i], exp_old[i]);
        compare_frame("abort_new", 35);
        if (got.size() > 35)
            check("abort_new_tuser", got[35].tuser, 1);

        // Reset during row 20, stray beats, then a clean frame
        fill_img(1'b0);
        build_exp();
        got.delete();
        send_range(0, 20*BPR + 2, 1'b0, 1'b0);
        aresetn = 1'b0;
        tick();
        reset_checks("midrst");
        aresetn = 1'b1;
        got.delete();
        for (int i = 0; i < 3; i++)
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        bus.s_tvalid = 1'b0;
        repeat (6) tick();
        check("drop_no_out", got.size(), 0);
        check("drop_tvalid", bus.m_tvalid, 0);
        fill_img(1'b0);
        build_exp();
        rnd_ready = 1'b1;
        send_range(0, NB, 1'b1, 1'b0);
        wait_outputs("f6_count", NB);
        compare_frame("f6", 0);
        rnd_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/row_window_gen.md
Name: row_window_gen

Overview:
- Vertical 3-row window generator for the streaming image filter path.
- Consumes raster-order pixel beats (one image row = IMAGE_DIM/PIXELS_PER_BEAT beats) on a valid/ready input.
- Holds the two previous rows in two internal line stores.
- Emits column-aligned beat triplets (row above, centre row, row below) to the downstream 3xN kernel, with border replication at the top and bottom rows and frame/row framing flags.

Parameters:
PIXELS_PER_BEAT, 16, pixels per beat
PIXEL_WIDTH, 8, bits per pixel
IMAGE_DIM, 512, image width and height in pixels (square frame)
DATA_WIDTH, PIXEL_WIDTH*PIXELS_PER_BEAT, beat width

Ports:
clk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_tdata  in  DATA_WIDTH  input pixel beat
s_tvalid  in  1  input beat valid
s_tready  out  1  input beat accepted when s_tvalid&s_tready
s_tuser  in  1  start of frame, on the first beat of row 0
s_tlast  in  1  end of row, on the last beat of each row
m_top  out  DATA_WIDTH  beat from centre row - 1
m_mid  out  DATA_WIDTH  beat from centre row
m_bot  out  DATA_WIDTH  beat from centre row + 1
m_tvalid  out  1  output triplet valid
m_tready  in  1  downstream ready
m_tuser  out  1  first beat of centre row 0
m_tlast  out  1  last beat of a centre row
m_first_row  out  1  centre row = 0
m_last_row  out  1  centre row = IMAGE_DIM-1
err_line_len  out  1  sticky framing error; cleared by reset or next accepted SOF

Behaviour:
- BPR = IMAGE_DIM/PIXELS_PER_BEAT (integer, power of two). Line stores L0 holds row r-1 and L1 holds row r-2. Each store has BPR entries of DATA_WIDTH bits.
- Input counters: col 0..BPR-1, row 0..IMAGE_DIM-1. Both wrap to 0 at the end of the frame.
- FSM states:
  - IDLE: s_tready=1. Beats without s_tuser are dropped. An accepted beat with s_tuser starts row 0 and goes to PRIME.
  - PRIME (row 0): write L0[col]<=beat. No output is produced. At col BPR-1, go to RUN.
  - RUN (rows 1..IMAGE_DIM-1): for an accepted beat at col c, read L0[c] and L1[c], then write L1[c]<=old L0[c] and L0[c]<=beat. Emit top=old L1[c], mid=old L0[c], bot=beat. For centre row 0, top is replaced by mid (replication). After the last beat of row IMAGE_DIM-1, go to FLUSH.
  - FLUSH: s_tready=0. Emit BPR beats with top=L1[c], mid=L0[c], bot=L0[c] (replication); no store writes. After c=BPR-1, go to IDLE.
- Pipeline: two stages (store read/input register, then output register).
  - An output beat is valid 2 cycles after the edge that accepted the corresponding input beat.
  - FLUSH beats follow the same 2-cycle latency from state entry.
- Backpressure: stall = m_tvalid & ~m_tready.
  - On stall, all pipeline registers, store read data and counters hold, and no store writes occur.
  - s_tready = ~stall in IDLE, PRIME and RUN.
  - Output data and flags must not change while m_tvalid=1 and m_tready=0.
- Flags are aligned with the output beat:
  - m_tlast at c=BPR-1.
  - m_tuser at c=0 of centre row 0.
  - m_first_row while centre row 0.
  - m_last_row while centre row IMAGE_DIM-1 (FLUSH beats).
- Framing errors set err_line_len; framing always follows the internal counters:
  - s_tlast at c!=BPR-1 is ignored.
  - Missing s_tlast at c=BPR-1: the row still closes.
  - s_tuser on a beat in PRIME/RUN other than row 0 col 0: abort the current frame, discard pipeline contents (m_tvalid drops after the in-flight output beat is accepted), and treat this beat as row 0 col 0 in PRIME.
- The stores need no reset. Their contents are never output before being written within the current frame.
- Reset values: m_tvalid=0, m_tuser=0, m_tlast=0, m_first_row=0, m_last_row=0, err_line_len=0, m_top/m_mid/m_bot=0, state=IDLE, counters=0. s_tready=1 in the cycle after reset.
- Reset mid-frame: all of the above apply in the next cycle and partial output is abandoned.

Test Plan:
- Use IMAGE_DIM=64, PIXELS_PER_BEAT=16 (BPR=4). Every pixel = row index. Full frame with m_tready=1, then check the following:
  - 256 input beats yield 256 outputs.
  - Centre row 0 gives top=mid=0x00.., bot=0x01...
  - Centre row 5 gives 04/05/06.
  - Centre row 63 gives 62/63/63 with m_last_row=1.
  - m_tlast is set on every 4th beat; m_tuser is set only on the first beat.
- Latency: first row-1 beat accepted at edge N -> m_tvalid=1 after edge N+2 with m_tuser=1 and m_first_row=1.
- Random m_tready (50%) and random s_tvalid gaps -> output sequence identical to the first test. No output change while stalled; no beat lost or duplicated.
- s_tlast on col 2 of row 3 -> err_line_len=1 and stays set; output data still matches the first test. A following frame's SOF clears the flag.
- SOF injected at row 10 col 1 -> err_line_len=1. The next 256+ outputs form a clean frame from the new SOF, the first with m_tuser=1 and top=mid.
- aresetn=0 for 1 cycle during RUN row 20 -> all outputs are at reset values next cycle. Non-SOF beats are then dropped until SOF, after which a full correct frame follows.
